// File: rtl/uart_tx_stream_pkg.sv
// Shared types and helpers for the streaming UART transmitter (package uart_pkg).
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} uart_tx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_stream_if.sv
// Valid/ready word stream feeding the UART transmitter FIFO.
interface uart_tx_stream_if #(parameter int DATA_BITS = 8);

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_tx_stream_sync_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; depth must be a power of 2.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (level == (AW+1)'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                level <= level + 1'b1;
            else if (do_pop && !do_push)
                level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_stream.sv
// Streaming UART transmitter: FIFO-buffered words serialised back-to-back.
// Optional parity stage is built only when UART_TX_PARITY_EN is defined.
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    uart_tx_stream_if.slave             stream,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int DIV   = calc_div(CLK_FREQ, BAUD);
    localparam int CNT_W = (DIV < 2) ? 1 : $clog2(DIV);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("uart_tx_stream: CLK_FREQ/BAUD must be at least 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
            $error("uart_tx_stream: DATA_BITS must be 5..8");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_tx_stream: STOP_BITS must be 1 or 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx_stream: FIFO_DEPTH must be a power of 2 and >= 2");
        end
        if (PARITY < PARITY_NONE || PARITY > PARITY_EVEN) begin : g_bad_parity
            $error("uart_tx_stream: PARITY must be 0, 1 or 2");
        end
    endgenerate

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = (PARITY != PARITY_NONE);
`endif

    uart_tx_state_t       state;
    logic [CNT_W-1:0]     baud_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] head;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 bit_done;
    logic                 last_stop;

    assign bit_done        = (baud_cnt == CNT_W'(DIV - 1));
    assign last_stop       = (bit_cnt == 3'(STOP_BITS - 1));
    assign stream.tx_ready = rst && !full;
    assign push            = stream.tx_valid && stream.tx_ready;
    assign pop             = !empty && ((state == IDLE) ||
                                        (state == STOP && bit_done && last_stop));
    assign busy            = (state != IDLE) || (fifo_level != '0);

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (stream.tx_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );

`ifdef UART_TX_PARITY_EN
    logic par_bit;
    logic par_next;

    always_comb begin
        par_next = (PARITY == PARITY_ODD) ? ~^head : ^head;
    end
`endif

    // Every transition happens on a bit boundary, so the wrap of baud_cnt doubles as the restart on state entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
`ifdef UART_TX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            baud_cnt <= bit_done ? '0 : baud_cnt + 1'b1;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    tx       <= 1'b1;
                    if (!empty) begin
                        shift   <= head;
                        bit_cnt <= '0;
                        state   <= START;
                        tx      <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        par_bit <= par_next;
`endif
                    end
                end
                START: begin
                    if (bit_done) begin
                        state <= DATA;
                        tx    <= shift[0];
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            if (PAR_EN) begin
                                state <= PAR;
                                tx    <= par_bit;
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PAR: begin
                    if (bit_done) begin
                        state   <= STOP;
                        tx      <= 1'b1;
                        bit_cnt <= '0;
                    end
                end
`endif
                STOP: begin
                    if (bit_done) begin
                        if (last_stop) begin
                            bit_cnt <= '0;
                            if (!empty) begin
                                shift <= head;
                                state <= START;
                                tx    <= 1'b0;
`ifdef UART_TX_PARITY_EN
                                par_bit <= par_next;
`endif
                            end else begin
                                state <= IDLE;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Directed bench for uart_tx_stream: several DUT configurations observed through one selector.
// Parity instances are added when UART_TX_PARITY_EN is defined.
module tb_uart_tx_stream;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int DIV      = 10;

    logic clk;
    logic rst;
    int   sel;
    int   checks;
    int   errors;

    logic       obs_tx;
    logic       obs_busy;
    logic       obs_ready;
    logic [31:0] obs_level;

    logic       tx_a, busy_a, tx_b, busy_b, tx_c, busy_c;
    logic [4:0] lvl_a;
    logic [2:0] lvl_b;
    logic [4:0] lvl_c;

    uart_tx_stream_if #(.DATA_BITS(8)) if_a ();
    uart_tx_stream_if #(.DATA_BITS(8)) if_b ();
    uart_tx_stream_if #(.DATA_BITS(5)) if_c ();

    uart_tx_stream #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut_a (
        .clk(clk), .rst(rst), .stream(if_a), .tx(tx_a), .busy(busy_a), .fifo_level(lvl_a));

    uart_tx_stream #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .stream(if_b), .tx(tx_b), .busy(busy_b), .fifo_level(lvl_b));

    uart_tx_stream #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(5), .STOP_BITS(2)) dut_c (
        .clk(clk), .rst(rst), .stream(if_c), .tx(tx_c), .busy(busy_c), .fifo_level(lvl_c));

`ifdef UART_TX_PARITY_EN
    logic       tx_d, busy_d, tx_e, busy_e;
    logic [4:0] lvl_d, lvl_e;

    uart_tx_stream_if #(.DATA_BITS(8)) if_d ();
    uart_tx_stream_if #(.DATA_BITS(8)) if_e ();

    uart_tx_stream #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .PARITY(2)) dut_d (
        .clk(clk), .rst(rst), .stream(if_d), .tx(tx_d), .busy(busy_d), .fifo_level(lvl_d));

    uart_tx_stream #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .PARITY(1)) dut_e (
        .clk(clk), .rst(rst), .stream(if_e), .tx(tx_e), .busy(busy_e), .fifo_level(lvl_e));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        obs_tx    = 1'b1;
        obs_busy  = 1'b0;
        obs_ready = 1'b0;
        obs_level = '0;
        case (sel)
            0: begin obs_tx = tx_a; obs_busy = busy_a; obs_ready = if_a.tx_ready; obs_level = 32'(lvl_a); end
            1: begin obs_tx = tx_b; obs_busy = busy_b; obs_ready = if_b.tx_ready; obs_level = 32'(lvl_b); end
            2: begin obs_tx = tx_c; obs_busy = busy_c; obs_ready = if_c.tx_ready; obs_level = 32'(lvl_c); end
`ifdef UART_TX_PARITY_EN
            3: begin obs_tx = tx_d; obs_busy = busy_d; obs_ready = if_d.tx_ready; obs_level = 32'(lvl_d); end
            4: begin obs_tx = tx_e; obs_busy = busy_e; obs_ready = if_e.tx_ready; obs_level = 32'(lvl_e); end
`endif
            default: ;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One-cycle push on the chosen instance; called and returns on a falling edge.
    task automatic applyStimulus(input int which, input logic [7:0] data);
        case (which)
            0: begin if_a.tx_data = data;      if_a.tx_valid = 1'b1; end
            1: begin if_b.tx_data = data;      if_b.tx_valid = 1'b1; end
            2: begin if_c.tx_data = data[4:0]; if_c.tx_valid = 1'b1; end
`ifdef UART_TX_PARITY_EN
            3: begin if_d.tx_data = data;      if_d.tx_valid = 1'b1; end
            4: begin if_e.tx_data = data;      if_e.tx_valid = 1'b1; end
`endif
            default: ;
        endcase
        @(negedge clk);
        if_a.tx_valid = 1'b0;
        if_b.tx_valid = 1'b0;
        if_c.tx_valid = 1'b0;
`ifdef UART_TX_PARITY_EN
        if_d.tx_valid = 1'b0;
        if_e.tx_valid = 1'b0;
`endif
    endtask

    // Entered on the first low cycle of a frame; returns exactly one frame length later.
    task automatic checkFrame(input string tag, input logic [7:0] data, input int nbits,
                              input int npar, input logic par, input int nstop);
        int   len;
        int   slot;
        logic exp_bit;
        len = (1 + nbits + npar + nstop) * DIV;
        checkOutput({tag, "_start_edge"}, 32'(obs_tx), 32'd0);
        for (int t = 1; t < len; t++) begin
            @(negedge clk);
            if (t == DIV - 1)
                checkOutput({tag, "_start_end"}, 32'(obs_tx), 32'd0);
            if (t == DIV)
                checkOutput({tag, "_bit0_edge"}, 32'(obs_tx), 32'(data[0]));
            if (t % DIV == DIV / 2) begin
                slot = t / DIV;
                if (slot == 0)
                    exp_bit = 1'b0;
                else if (slot <= nbits)
                    exp_bit = data[slot-1];
                else if (npar != 0 && slot == nbits + 1)
                    exp_bit = par;
                else
                    exp_bit = 1'b1;
                checkOutput($sformatf("%s_slot%0d", tag, slot), 32'(obs_tx), 32'(exp_bit));
            end
            if (t == len - 1) begin
                checkOutput({tag, "_stop_end"}, 32'(obs_tx), 32'd1);
                checkOutput({tag, "_busy_end"}, 32'(obs_busy), 32'd1);
            end
        end
        @(negedge clk);
    endtask

    int   acc;
    logic fire;
    int   edges;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        sel    = 0;
        rst    = 1'b0;
        if_a.tx_valid = 1'b0; if_a.tx_data = '0;
        if_b.tx_valid = 1'b0; if_b.tx_data = '0;
        if_c.tx_valid = 1'b0; if_c.tx_data = '0;
`ifdef UART_TX_PARITY_EN
        if_d.tx_valid = 1'b0; if_d.tx_data = '0;
        if_e.tx_valid = 1'b0; if_e.tx_data = '0;
`endif
        repeat (3) @(negedge clk);
        checkOutput("rst_tx", 32'(obs_tx), 32'd1);
        checkOutput("rst_busy", 32'(obs_busy), 32'd0);
        checkOutput("rst_level", obs_level, 32'd0);
        checkOutput("rst_ready", 32'(obs_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_ready", 32'(obs_ready), 32'd1);

        // Single word 0x4D, no parity
        applyStimulus(0, 8'h4D);
        checkOutput("t2_level", obs_level, 32'd1);
        checkOutput("t2_tx_pre", 32'(obs_tx), 32'd1);
        checkOutput("t2_busy", 32'(obs_busy), 32'd1);
        @(negedge clk);
        checkFrame("t2", 8'h4D, 8, 0, 1'b0, 1);
        checkOutput("t2_busy_fall", 32'(obs_busy), 32'd0);
        checkOutput("t2_level_end", obs_level, 32'd0);

        // Three back-to-back words: the second push coincides with the first pop
        fork
            begin
                applyStimulus(0, 8'h01);
                checkOutput("t4_level_a", obs_level, 32'd1);
                applyStimulus(0, 8'h02);
                checkOutput("t4_level_b", obs_level, 32'd1);
                applyStimulus(0, 8'h03);
                checkOutput("t4_level_c", obs_level, 32'd2);
            end
            begin
                repeat (2) @(negedge clk);
                checkFrame("t4_w0", 8'h01, 8, 0, 1'b0, 1);
                checkOutput("t4_level_d", obs_level, 32'd1);
                checkFrame("t4_w1", 8'h02, 8, 0, 1'b0, 1);
                checkOutput("t4_level_e", obs_level, 32'd0);
                checkFrame("t4_w2", 8'h03, 8, 0, 1'b0, 1);
                checkOutput("t4_busy_end", 32'(obs_busy), 32'd0);
            end
        join

        // Reset in the middle of a start bit with a word still queued
        applyStimulus(0, 8'hAA);
        applyStimulus(0, 8'h55);
        repeat (5) @(negedge clk);
        checkOutput("t1_in_frame", 32'(obs_tx), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t1_tx", 32'(obs_tx), 32'd1);
        checkOutput("t1_busy", 32'(obs_busy), 32'd0);
        checkOutput("t1_level", obs_level, 32'd0);
        checkOutput("t1_ready", 32'(obs_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        edges = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (obs_tx !== 1'b1) edges++;
        end
        checkOutput("t1_quiet", 32'(edges), 32'd0);
        checkOutput("t1_idle_busy", 32'(obs_busy), 32'd0);

        // Depth-4 FIFO saturated by a continuously valid source
        sel = 1;
        @(negedge clk);
        fork
            begin
                acc = 0;
                if_b.tx_data  = 8'hA0;
                if_b.tx_valid = 1'b1;
                for (int c = 0; c < 600 && acc < 7; c++) begin
                    fire = obs_ready;
                    @(negedge clk);
                    if (fire) begin
                        acc++;
                        if (acc == 2) checkOutput("t5_level_pushpop", obs_level, 32'd1);
                        if (acc == 5) begin
                            checkOutput("t5_level_full", obs_level, 32'd4);
                            checkOutput("t5_ready_full", 32'(obs_ready), 32'd0);
                        end
                        if_b.tx_data = 8'(8'hA0 + acc);
                        if (acc == 7) if_b.tx_valid = 1'b0;
                    end
                end
                if_b.tx_valid = 1'b0;
                checkOutput("t5_accepted", 32'(acc), 32'd7);
            end
            begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 7; i++)
                    checkFrame($sformatf("t5_w%0d", i), 8'(8'hA0 + i), 8, 0, 1'b0, 1);
                checkOutput("t5_busy_end", 32'(obs_busy), 32'd0);
                checkOutput("t5_level_end", obs_level, 32'd0);
            end
        join

        // Five data bits, two stop bits
        sel = 2;
        @(negedge clk);
        applyStimulus(2, 8'h15);
        @(negedge clk);
        checkFrame("t6", 8'h15, 5, 0, 1'b0, 2);
        checkOutput("t6_busy_end", 32'(obs_busy), 32'd0);

`ifdef UART_TX_PARITY_EN
        // 0x53 has four ones: even parity bit 0, odd parity bit 1
        sel = 3;
        @(negedge clk);
        applyStimulus(3, 8'h53);
        @(negedge clk);
        checkFrame("t3_even", 8'h53, 8, 1, 1'b0, 1);
        checkOutput("t3_even_busy_end", 32'(obs_busy), 32'd0);
        sel = 4;
        @(negedge clk);
        applyStimulus(4, 8'h53);
        @(negedge clk);
        checkFrame("t3_odd", 8'h53, 8, 1, 1'b1, 1);
        checkOutput("t3_odd_busy_end", 32'(obs_busy), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
